// File: rtl/round_sequencer_pkg.sv
// Shared definitions for the round sequencer: game state codes, LFSR seed, symbol width.
package round_sequencer_pkg;

  localparam int SYM_W = 4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_LEVELUP = 3'd2,
    ST_WIN     = 3'd3,
    ST_LOSE    = 3'd4
  } state_t;

endpackage

// File: rtl/round_sequencer_lfsr16.sv
// 16-bit Galois LFSR (taps 16,14,13,11), advancing whenever enable is high.
module lfsr16
  import round_sequencer_pkg::*;
(
  input  logic        Clk100M,
  input  logic        Reset,
  input  logic        enable,
  output logic [15:0] value
);

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      value <= LFSR_SEED;
    end else if (enable) begin
      value <= {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);
    end
  end

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: paces symbols, tallies hits/misses, hands level advance
// to the level controller and reports win/loss.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int HITS_PER_LEVEL = 8,
  parameter int LIVES          = 3
) (
  input  logic             Clk100M,
  input  logic             Reset,
  input  logic             start,
  input  logic             hit,
  input  logic             miss,
  input  logic             newLevel,
  input  logic             victory,
  input  logic [31:0]      symGenMax,
  output logic             incLevel,
  output logic             symValid,
  output logic [SYM_W-1:0] symbol,
  output logic [15:0]      score,
  output logic [1:0]       lives,
  output logic [2:0]       gameState
);

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0] HITS_TARGET = 8'(HITS_PER_LEVEL);

  state_t           state, stateNext;
  logic [31:0]      divider, dividerNext;
  logic [7:0]       hitCnt, hitCntNext;
  logic [15:0]      scoreNext;
  logic [1:0]       livesNext;
  logic             incLevelNext, symValidNext;
  logic [SYM_W-1:0] symbolNext;
  logic [15:0]      lfsrValue;
  logic [31:0]      period;
  logic             divWrap;

  lfsr16 u_lfsr (
    .Clk100M (Clk100M),
    .Reset   (Reset),
    .enable  (1'b1),
    .value   (lfsrValue)
  );

  // ">=" rather than "==" so a period shrinking below the current count wraps at once.
  assign period    = (symGenMax == 32'd0) ? 32'd1 : symGenMax;
  assign divWrap   = (divider >= (period - 32'd1));
  assign gameState = state;

  always_ff @(posedge Clk100M or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      divider  <= 32'd0;
      hitCnt   <= 8'd0;
      score    <= 16'd0;
      lives    <= LIVES_INIT;
      incLevel <= 1'b0;
      symValid <= 1'b0;
      symbol   <= 4'h1;
    end else begin
      state    <= stateNext;
      divider  <= dividerNext;
      hitCnt   <= hitCntNext;
      score    <= scoreNext;
      lives    <= livesNext;
      incLevel <= incLevelNext;
      symValid <= symValidNext;
      symbol   <= symbolNext;
    end
  end

  always_comb begin
    stateNext    = state;
    dividerNext  = divider;
    hitCntNext   = hitCnt;
    scoreNext    = score;
    livesNext    = lives;
    incLevelNext = 1'b0;
    symValidNext = 1'b0;
    symbolNext   = symbol;

    case (state)
      ST_IDLE: begin
        if (start) begin
          stateNext   = ST_PLAY;
          scoreNext   = 16'd0;
          hitCntNext  = 8'd0;
          dividerNext = 32'd0;
          livesNext   = LIVES_INIT;
        end
      end

      ST_PLAY: begin
        dividerNext = divWrap ? 32'd0 : divider + 32'd1;
        if (miss) begin
          if (lives <= 2'd1) begin
            livesNext = 2'd0;
            stateNext = ST_LOSE;
          end else begin
            livesNext = lives - 2'd1;
          end
        end else if (hit) begin
          if (score != 16'hFFFF) scoreNext = score + 16'd1;
          if (hitCnt + 8'd1 == HITS_TARGET) begin
            hitCntNext   = 8'd0;
            incLevelNext = 1'b1;
            stateNext    = ST_LEVELUP;
          end else begin
            hitCntNext = hitCnt + 8'd1;
          end
        end
        // No symbol is presented on the cycle the round is left.
        if (divWrap && stateNext == ST_PLAY) begin
          symValidNext = 1'b1;
          symbolNext   = (lfsrValue[3:0] == 4'h0) ? 4'hF : lfsrValue[3:0];
        end
      end

      ST_LEVELUP: begin
        // The controller's answer is only trusted once incLevel has been seen.
        if (!incLevel) begin
          if (victory) begin
            stateNext = ST_WIN;
          end else if (newLevel) begin
            stateNext   = ST_PLAY;
            dividerNext = 32'd0;
          end
        end
      end

      ST_WIN, ST_LOSE: begin
        if (start) stateNext = ST_IDLE;
      end

      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with HITS_PER_LEVEL=2, LIVES=3.
module tb_round_sequencer;
  import round_sequencer_pkg::*;

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_PLAY    = ST_PLAY;
  localparam logic [2:0] S_LEVELUP = ST_LEVELUP;
  localparam logic [2:0] S_WIN     = ST_WIN;
  localparam logic [2:0] S_LOSE    = ST_LOSE;

  logic        Clk100M = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0, hit = 1'b0, miss = 1'b0, newLevel = 1'b0, victory = 1'b0;
  logic [31:0] symGenMax = 32'd5;
  logic        incLevel, symValid;
  logic [3:0]  symbol;
  logic [15:0] score;
  logic [1:0]  lives;
  logic [2:0]  gameState;

  int n_checks = 0;
  int n_fail = 0;

  round_sequencer #(.HITS_PER_LEVEL(2), .LIVES(3)) dut (
    .Clk100M(Clk100M), .Reset(Reset), .start(start), .hit(hit), .miss(miss),
    .newLevel(newLevel), .victory(victory), .symGenMax(symGenMax),
    .incLevel(incLevel), .symValid(symValid), .symbol(symbol), .score(score),
    .lives(lives), .gameState(gameState)
  );

  always #5 Clk100M = ~Clk100M;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge Clk100M);
    @(negedge Clk100M);
  endtask

  task automatic test_reset();
    #12;
    n_checks++; if (gameState !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", gameState, S_IDLE); end
    n_checks++; if (symbol !== 4'h1) begin n_fail++; $display("FAIL reset_symbol: got %0h expected 1", symbol); end
    n_checks++; if (score !== 16'd0) begin n_fail++; $display("FAIL reset_score: got %0d expected 0", score); end
    n_checks++; if (lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives: got %0d expected 3", lives); end
    n_checks++; if (incLevel !== 1'b0 || symValid !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got inc=%0b sv=%0b expected 0 0", incLevel, symValid); end
    @(negedge Clk100M);
    Reset = 1'b0;
    tick();
    n_checks++; if (gameState !== S_IDLE) begin n_fail++; $display("FAIL idle_hold: got %0d expected %0d", gameState, S_IDLE); end
  endtask

  task automatic test_play_symbols();
    logic [3:0] prev;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (gameState !== S_PLAY) begin n_fail++; $display("FAIL start_play: got %0d expected %0d", gameState, S_PLAY); end
    prev = symbol;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++; if (symValid !== (i % 5 == 0)) begin n_fail++; $display("FAIL symvalid_period cyc %0d: got %0b expected %0b", i, symValid, (i % 5 == 0)); end
      n_checks++; if (symbol === 4'h0) begin n_fail++; $display("FAIL symbol_nonzero cyc %0d: got 0 expected nonzero", i); end
      if (!symValid) begin
        n_checks++; if (symbol !== prev) begin n_fail++; $display("FAIL symbol_stable cyc %0d: got %0h expected %0h", i, symbol, prev); end
      end
      n_checks++; if (gameState !== S_PLAY) begin n_fail++; $display("FAIL play_state cyc %0d: got %0d expected %0d", i, gameState, S_PLAY); end
      prev = symbol;
    end
  endtask

  task automatic test_levelup();
    hit = 1'b1; tick();
    n_checks++; if (score !== 16'd1 || incLevel !== 1'b0 || gameState !== S_PLAY) begin n_fail++; $display("FAIL first_hit: got score=%0d inc=%0b st=%0d expected 1 0 %0d", score, incLevel, gameState, S_PLAY); end
    tick(); hit = 1'b0;
    n_checks++; if (score !== 16'd2) begin n_fail++; $display("FAIL second_hit_score: got %0d expected 2", score); end
    n_checks++; if (incLevel !== 1'b1 || gameState !== S_LEVELUP) begin n_fail++; $display("FAIL inclevel_pulse: got inc=%0b st=%0d expected 1 %0d", incLevel, gameState, S_LEVELUP); end
    // newLevel in the incLevel cycle must be ignored; hits are ignored in LEVELUP
    newLevel = 1'b1; hit = 1'b1; tick(); hit = 1'b0;
    n_checks++; if (incLevel !== 1'b0 || gameState !== S_LEVELUP || score !== 16'd2) begin n_fail++; $display("FAIL levelup_hold: got inc=%0b st=%0d score=%0d expected 0 %0d 2", incLevel, gameState, score, S_LEVELUP); end
    n_checks++; if (symValid !== 1'b0) begin n_fail++; $display("FAIL levelup_symvalid: got %0b expected 0", symValid); end
    tick(); newLevel = 1'b0;
    n_checks++; if (gameState !== S_PLAY) begin n_fail++; $display("FAIL newlevel_play: got %0d expected %0d", gameState, S_PLAY); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++; if (symValid !== (i == 5)) begin n_fail++; $display("FAIL divider_restart cyc %0d: got %0b expected %0b", i, symValid, (i == 5)); end
      n_checks++; if (incLevel !== 1'b0) begin n_fail++; $display("FAIL no_stray_inclevel cyc %0d: got 1 expected 0", i); end
    end
  endtask

  task automatic test_win();
    hit = 1'b1; tick(); tick(); hit = 1'b0;
    n_checks++; if (gameState !== S_LEVELUP || score !== 16'd4) begin n_fail++; $display("FAIL win_levelup: got st=%0d score=%0d expected %0d 4", gameState, score, S_LEVELUP); end
    victory = 1'b1; newLevel = 1'b1; tick();
    n_checks++; if (gameState !== S_LEVELUP) begin n_fail++; $display("FAIL victory_early: got %0d expected %0d", gameState, S_LEVELUP); end
    tick(); newLevel = 1'b0;
    n_checks++; if (gameState !== S_WIN) begin n_fail++; $display("FAIL victory_priority: got %0d expected %0d", gameState, S_WIN); end
    hit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (score !== 16'd4 || symValid !== 1'b0 || gameState !== S_WIN) begin n_fail++; $display("FAIL win_frozen cyc %0d: got score=%0d sv=%0b st=%0d expected 4 0 %0d", i, score, symValid, gameState, S_WIN); end
    end
    hit = 1'b0; victory = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (gameState !== S_IDLE) begin n_fail++; $display("FAIL win_to_idle: got %0d expected %0d", gameState, S_IDLE); end
  endtask

  task automatic test_lose();
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (score !== 16'd0 || lives !== 2'd3 || gameState !== S_PLAY) begin n_fail++; $display("FAIL restart: got score=%0d lives=%0d st=%0d expected 0 3 %0d", score, lives, gameState, S_PLAY); end
    hit = 1'b1; tick();
    n_checks++; if (score !== 16'd1) begin n_fail++; $display("FAIL lose_hit: got %0d expected 1", score); end
    miss = 1'b1; tick(); hit = 1'b0;
    n_checks++; if (lives !== 2'd2 || score !== 16'd1) begin n_fail++; $display("FAIL hit_miss_priority: got lives=%0d score=%0d expected 2 1", lives, score); end
    tick();
    n_checks++; if (lives !== 2'd1 || gameState !== S_PLAY) begin n_fail++; $display("FAIL second_miss: got lives=%0d st=%0d expected 1 %0d", lives, gameState, S_PLAY); end
    tick(); miss = 1'b0;
    n_checks++; if (lives !== 2'd0 || gameState !== S_LOSE) begin n_fail++; $display("FAIL third_miss: got lives=%0d st=%0d expected 0 %0d", lives, gameState, S_LOSE); end
    hit = 1'b1; tick(); tick(); hit = 1'b0;
    n_checks++; if (score !== 16'd1 || symValid !== 1'b0 || gameState !== S_LOSE) begin n_fail++; $display("FAIL lose_frozen: got score=%0d sv=%0b st=%0d expected 1 0 %0d", score, symValid, gameState, S_LOSE); end
    start = 1'b1; tick(); start = 1'b0;
    n_checks++; if (gameState !== S_IDLE) begin n_fail++; $display("FAIL lose_to_idle: got %0d expected %0d", gameState, S_IDLE); end
  endtask

  task automatic test_divider_shrink();
    symGenMax = 32'd100;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick();
      n_checks++; if (symValid !== 1'b0) begin n_fail++; $display("FAIL long_period cyc %0d: got 1 expected 0", i); end
    end
    symGenMax = 32'd5; tick();
    n_checks++; if (symValid !== 1'b1) begin n_fail++; $display("FAIL shrink_wrap: got %0b expected 1", symValid); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_checks++; if (symValid !== (i == 5)) begin n_fail++; $display("FAIL shrink_period cyc %0d: got %0b expected %0b", i, symValid, (i == 5)); end
    end
    symGenMax = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (symValid !== 1'b1) begin n_fail++; $display("FAIL zero_period cyc %0d: got %0b expected 1", i, symValid); end
    end
  endtask

  task automatic test_reset_midplay();
    symGenMax = 32'd5;
    hit = 1'b1; tick(); hit = 1'b0;
    n_checks++; if (score !== 16'd1 || incLevel !== 1'b0) begin n_fail++; $display("FAIL pre_reset_hit: got score=%0d inc=%0b expected 1 0", score, incLevel); end
    hit = 1'b1;
    @(posedge Clk100M); #1; hit = 1'b0;
    n_checks++; if (incLevel !== 1'b1) begin n_fail++; $display("FAIL pre_reset_inclevel: got %0b expected 1", incLevel); end
    Reset = 1'b1; #1;
    n_checks++; if (gameState !== S_IDLE || incLevel !== 1'b0 || symValid !== 1'b0) begin n_fail++; $display("FAIL async_reset_ctrl: got st=%0d inc=%0b sv=%0b expected %0d 0 0", gameState, incLevel, symValid, S_IDLE); end
    n_checks++; if (symbol !== 4'h1 || score !== 16'd0 || lives !== 2'd3) begin n_fail++; $display("FAIL async_reset_data: got sym=%0h score=%0d lives=%0d expected 1 0 3", symbol, score, lives); end
    @(negedge Clk100M); Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++; if (incLevel !== 1'b0 || gameState !== S_IDLE) begin n_fail++; $display("FAIL post_reset cyc %0d: got inc=%0b st=%0d expected 0 %0d", i, incLevel, gameState, S_IDLE); end
    end
  endtask

  initial begin
    test_reset();
    test_play_symbols();
    test_levelup();
    test_win();
    test_lose();
    test_divider_shrink();
    test_reset_midplay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
